// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/exec/mem/wb
// over the shared datapath, drives the immediate extender and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       ext_op,
  output logic             reg_write,
  output logic             wd_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_NONE
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, dec_cls;
  logic [2:0]       dec_ext, ext_q, ext_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             br_taken, exec_br;
  logic             mem_we_q, iord_q, alu_src_b_q, reg_write_q, wd_sel_q, illegal_q;
  logic [1:0]       alu_op_q;

  // ALU function decoding from funct7b5 lives in the ALU decoder, not here.
  logic unused_funct7b5;
  assign unused_funct7b5 = funct7b5;

  always_comb begin
    dec_cls = C_NONE;
    dec_ext = 3'b000;
    unique case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: begin
        dec_cls = C_IALU;
        dec_ext = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b011 : 3'b010;
      end
      7'b0000011: begin dec_cls = C_LOAD;   dec_ext = 3'b010; end
      7'b0100011: begin dec_cls = C_STORE;  dec_ext = 3'b001; end
      7'b1100011: begin dec_cls = C_BRANCH; dec_ext = 3'b100; end
      default:    ;
    endcase
  end

  assign br_taken = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_cls == C_NONE) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
          cls_d   = dec_cls;
        end
      end
      S_EXEC: begin
        unique case (cls_q)
          C_R, C_IALU:     state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (cls_q == C_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Extender select is live-decoded in DECODE, then held until the instruction ends.
  always_comb begin
    ext_d = ext_q;
    if (state_q == S_DECODE && state_d == S_EXEC) ext_d = dec_ext;
    else if (state_d == S_FETCH || state_d == S_TRAP) ext_d = 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      cls_q       <= C_NONE;
      ext_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      iord_q      <= 1'b0;
      alu_src_b_q <= 1'b0;
      alu_op_q    <= '0;
      reg_write_q <= 1'b0;
      wd_sel_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      ext_q       <= ext_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
      mem_we_q    <= (state_d == S_MEM) && (cls_d == C_STORE);
      iord_q      <= (state_d == S_MEM);
      alu_src_b_q <= (state_d == S_EXEC) &&
                     (cls_d == C_IALU || cls_d == C_LOAD || cls_d == C_STORE);
      if (state_d == S_EXEC && (cls_d == C_R || cls_d == C_IALU))
        alu_op_q <= 2'b10;
      else if (state_d == S_EXEC && cls_d == C_BRANCH)
        alu_op_q <= 2'b01;
      else
        alu_op_q <= 2'b00;
      reg_write_q <= (state_d == S_WB);
      wd_sel_q    <= (state_d == S_WB) && (cls_d == C_LOAD);
      illegal_q   <= (state_d == S_TRAP);
    end
  end

  // Request and ack-qualified strobes are gated by rst so they drop the moment reset rises.
  assign mem_req   = !rst && (state_q == S_FETCH || state_q == S_MEM);
  assign ir_write  = !rst && (state_q == S_FETCH) && mem_ack;
  assign exec_br   = !rst && (state_q == S_EXEC) && (cls_q == C_BRANCH) && br_taken;
  assign pc_write  = ir_write || exec_br;
  assign pc_src    = exec_br;
  assign mem_we    = mem_we_q;
  assign iord      = iord_q;
  assign alu_src_b = alu_src_b_q;
  assign alu_op    = alu_op_q;
  assign ext_op    = (state_q == S_DECODE) ? dec_ext : ext_q;
  assign reg_write = reg_write_q;
  assign wd_sel    = wd_sel_q;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule
